// File: rtl/stopwatch_ctrl_if.sv
// Command and display bundle between the button front-end and the stopwatch controller.
// master drives command pulses, slave (the controller) drives the display/status side.
interface stopwatch_ctrl_if;
    logic       start_stop;
    logic       lap;
    logic       clear;
    logic [3:0] sec_ones;
    logic [2:0] sec_tens;
    logic [3:0] min_ones;
    logic       tick;
    logic       rollover;
    logic       running;
    logic       lap_active;

    modport master (
        output start_stop, lap, clear,
        input  sec_ones, sec_tens, min_ones, tick, rollover, running, lap_active
    );

    modport slave (
        input  start_stop, lap, clear,
        output sec_ones, sec_tens, min_ones, tick, rollover, running, lap_active
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Start/stop/lap/clear stopwatch: prescaler plus M:SS digit chain (0:00..9:59),
// lap-freeze display mux and a one-cycle rollover pulse on the 9:59 -> 0:00 wrap.
//
//   state  | meaning
//   IDLE   | count zeroed, waiting for start
//   RUN    | counting, display shows live digits
//   LAP    | counting, display frozen on captured lap digits
//   STOP   | count held, display shows live digits
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned DIV_W    = 26
) (
    input  logic             clk,
    input  logic             reset,
    stopwatch_ctrl_if.slave  sw
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_LAP  = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] PRESC_ONE  = DIV_W'(1);

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [3:0]       sec_ones_q, sec_ones_d;
    logic [2:0]       sec_tens_q, sec_tens_d;
    logic [3:0]       min_ones_q, min_ones_d;
    logic [3:0]       lap_ones_q, lap_ones_d;
    logic [2:0]       lap_tens_q, lap_tens_d;
    logic [3:0]       lap_min_q, lap_min_d;
    logic             rollover_q, rollover_d;

    logic             counting;
    logic             tick_w;
    logic             wrap;
    logic             zero_all;
    logic             capture;
    logic [3:0]       live_ones;
    logic [2:0]       live_tens;
    logic [3:0]       live_min;

    assign counting = (state_q == S_RUN) || (state_q == S_LAP);
    assign tick_w   = counting && (presc_q == PRESC_LAST);

    // Digit chain advance; wrap flags the full 9:59 -> 0:00 carry-out.
    always_comb begin
        live_ones = sec_ones_q;
        live_tens = sec_tens_q;
        live_min  = min_ones_q;
        wrap      = 1'b0;
        if (tick_w) begin
            if (sec_ones_q == 4'd9) begin
                live_ones = 4'd0;
                if (sec_tens_q == 3'd5) begin
                    live_tens = 3'd0;
                    if (min_ones_q == 4'd9) begin
                        live_min = 4'd0;
                        wrap     = 1'b1;
                    end else begin
                        live_min = min_ones_q + 4'd1;
                    end
                end else begin
                    live_tens = sec_tens_q + 3'd1;
                end
            end else begin
                live_ones = sec_ones_q + 4'd1;
            end
        end
    end

    // Command decode: the highest-priority command that is valid in the current state acts.
    always_comb begin
        state_d  = state_q;
        zero_all = 1'b0;
        capture  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sw.clear) begin
                    zero_all = 1'b1;
                end else if (sw.start_stop) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (sw.start_stop) begin
                    state_d = S_STOP;
                end else if (sw.lap) begin
                    state_d = S_LAP;
                    capture = 1'b1;
                end
            end
            S_LAP: begin
                if (sw.start_stop) begin
                    state_d = S_STOP;
                end else if (sw.lap) begin
                    state_d = S_RUN;
                end
            end
            S_STOP: begin
                if (sw.clear) begin
                    state_d  = S_IDLE;
                    zero_all = 1'b1;
                end else if (sw.start_stop) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        presc_d = presc_q;
        if (counting) begin
            presc_d = tick_w ? '0 : presc_q + PRESC_ONE;
        end

        sec_ones_d = live_ones;
        sec_tens_d = live_tens;
        min_ones_d = live_min;

        // Lap captures the post-edge live value so a same-edge tick is included.
        lap_ones_d = capture ? live_ones : lap_ones_q;
        lap_tens_d = capture ? live_tens : lap_tens_q;
        lap_min_d  = capture ? live_min  : lap_min_q;

        rollover_d = wrap;

        if (zero_all) begin
            presc_d    = '0;
            sec_ones_d = 4'd0;
            sec_tens_d = 3'd0;
            min_ones_d = 4'd0;
            lap_ones_d = 4'd0;
            lap_tens_d = 3'd0;
            lap_min_d  = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 3'd0;
            min_ones_q <= 4'd0;
            lap_ones_q <= 4'd0;
            lap_tens_q <= 3'd0;
            lap_min_q  <= 4'd0;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            lap_ones_q <= lap_ones_d;
            lap_tens_q <= lap_tens_d;
            lap_min_q  <= lap_min_d;
            rollover_q <= rollover_d;
        end
    end

    assign sw.sec_ones   = (state_q == S_LAP) ? lap_ones_q : sec_ones_q;
    assign sw.sec_tens   = (state_q == S_LAP) ? lap_tens_q : sec_tens_q;
    assign sw.min_ones   = (state_q == S_LAP) ? lap_min_q  : min_ones_q;
    assign sw.tick       = tick_w;
    assign sw.rollover   = rollover_q;
    assign sw.running    = counting;
    assign sw.lap_active = (state_q == S_LAP);

endmodule
